// File: rtl/cheby_mac_seq.sv
// rtl/cheby_mac_seq.sv - Chebyshev term multiply-accumulate sequencer with saturated Q15 output
// Walks the T-value ROM, accumulates c_k*T_k(x) and hands y(x) downstream over valid/ready.
module cheby_mac_seq #(
  parameter int N_TERMS = 8
) (
  input  logic        c_clk,
  input  logic        c_rst,
  input  logic        c_start,
  input  logic        i_coef_wr,
  input  logic [2:0]  i_coef_addr,
  input  logic [15:0] i_coef_data,
  output logic [2:0]  o_rom_address,
  output logic        o_rom_read_en,
  output logic        o_rom_ce,
  output logic        o_rom_tri_output,
  input  logic [15:0] i_rom_data,
  output logic [15:0] o_result,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN, S_OUT} state_t;

  localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic signed [35:0] acc_q, acc_d;
  logic signed [31:0] p_q, p_d;
  logic               pvalid_q, pvalid_d;
  logic [15:0]        result_q, result_d;
  logic               valid_q, valid_d;
  logic [15:0]        coef_q [8];
  logic [15:0]        coef_d [8];

  logic signed [35:0] p_ext;
  logic signed [35:0] acc_shr;

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      pvalid_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < 8; i++) coef_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      pvalid_q <= pvalid_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      for (int i = 0; i < 8; i++) coef_q[i] <= coef_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (c_start) state_d = S_RUN;
      S_RUN:   if (k_q == K_LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_OUT;
      S_OUT:   if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Product is registered one edge before it is summed, hence the DRAIN edge.
  always_comb begin
    k_d      = k_q;
    acc_d    = acc_q;
    p_d      = p_q;
    pvalid_d = pvalid_q;
    result_d = result_q;
    valid_d  = valid_q;
    for (int i = 0; i < 8; i++) coef_d[i] = coef_q[i];
    p_ext    = {{4{p_q[31]}}, p_q};
    acc_shr  = acc_q >>> 15;

    if (i_coef_wr && state_q == S_IDLE) coef_d[i_coef_addr] = i_coef_data;

    case (state_q)
      S_IDLE: begin
        if (c_start) begin
          acc_d    = '0;
          k_d      = '0;
          pvalid_d = 1'b0;
        end
      end
      S_RUN: begin
        p_d      = $signed(i_rom_data) * $signed(coef_q[k_q]);
        pvalid_d = 1'b1;
        if (pvalid_q) acc_d = acc_q + p_ext;
        k_d      = k_q + 3'd1;
      end
      S_DRAIN: begin
        acc_d    = acc_q + p_ext;
        pvalid_d = 1'b0;
      end
      S_FIN: begin
        if (acc_shr > 36'sd32767)       result_d = 16'h7FFF;
        else if (acc_shr < -36'sd32768) result_d = 16'h8000;
        else                            result_d = acc_shr[15:0];
        valid_d = 1'b1;
      end
      S_OUT: begin
        if (i_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_busy           = (state_q != S_IDLE);
    o_rom_ce         = (state_q == S_RUN);
    o_rom_read_en    = (state_q == S_RUN);
    o_rom_tri_output = (state_q != S_RUN);
    o_rom_address    = (state_q == S_RUN) ? k_q : 3'd0;
    o_result         = result_q;
    o_valid          = valid_q;
  end

endmodule

// File: tb/tb_cheby_mac_seq.sv
// tb/tb_cheby_mac_seq.sv - directed scoreboard bench for cheby_mac_seq
module tb_cheby_mac_seq;

  logic        c_clk = 1'b0;
  logic        c_rst;
  logic        c_start;
  logic        i_coef_wr;
  logic [2:0]  i_coef_addr;
  logic [15:0] i_coef_data;
  logic [2:0]  o_rom_address;
  logic        o_rom_read_en;
  logic        o_rom_ce;
  logic        o_rom_tri_output;
  logic [15:0] i_rom_data;
  logic [15:0] o_result;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  logic [15:0] rom_mem [8];
  logic [15:0] coef_m  [8];
  logic [15:0] exp_q [$];
  int          total  = 0;
  int          passed = 0;

  always #5 c_clk = ~c_clk;

  assign i_rom_data = rom_mem[o_rom_address];

  cheby_mac_seq #(.N_TERMS(8)) dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_start(c_start),
    .i_coef_wr(i_coef_wr), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_rom_address(o_rom_address), .o_rom_read_en(o_rom_read_en), .o_rom_ce(o_rom_ce),
    .o_rom_tri_output(o_rom_tri_output), .i_rom_data(i_rom_data),
    .o_result(o_result), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model();
    longint s = 0;
    for (int k = 0; k < 8; k++)
      s += longint'($signed(coef_m[k])) * longint'($signed(rom_mem[k]));
    s = s >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
    i_coef_wr = 1'b1; i_coef_addr = a; i_coef_data = d;
    @(posedge c_clk); #1;
    i_coef_wr = 1'b0;
    coef_m[a] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 36'(o_valid), 36'd0);
    check({tag, "_busy"}, 36'(o_busy), 36'd0);
    check({tag, "_ce"}, 36'(o_rom_ce), 36'd0);
    check({tag, "_rd"}, 36'(o_rom_read_en), 36'd0);
    check({tag, "_tri"}, 36'(o_rom_tri_output), 36'd1);
    check({tag, "_addr"}, 36'(o_rom_address), 36'd0);
  endtask

  // Each task starts and ends 1 time unit after a rising edge.
  task automatic run(input bit bp, input bit rdy_early, input bit busy_wr,
                     input bit start_wr, input logic [2:0] wa, input logic [15:0] wd);
    int n;
    int ce_cnt;
    logic [15:0] held;
    if (start_wr) begin
      i_coef_wr = 1'b1; i_coef_addr = wa; i_coef_data = wd;
      coef_m[wa] = wd;
    end
    exp_q.push_back(model());
    i_ready = rdy_early;
    c_start = 1'b1;
    @(posedge c_clk); #1;
    c_start = 1'b0; i_coef_wr = 1'b0;
    n = 0; ce_cnt = 0;
    while (n < 40 && o_valid !== 1'b1) begin
      if (o_rom_ce === 1'b1) begin
        check("rom_addr", 36'(o_rom_address), 36'(ce_cnt));
        check("rom_rd", 36'(o_rom_read_en), 36'd1);
        check("rom_tri", 36'(o_rom_tri_output), 36'd0);
        ce_cnt++;
      end
      if (busy_wr && n == 2) begin
        i_coef_wr = 1'b1; i_coef_addr = 3'd3; i_coef_data = 16'h1234;
      end else begin
        i_coef_wr = 1'b0;
      end
      @(posedge c_clk); #1;
      n++;
    end
    i_coef_wr = 1'b0;
    check("valid_latency", 36'(n), 36'd10);
    check("ce_cycles", 36'(ce_cnt), 36'd8);
    if (exp_q.size() == 0) check("sb_underflow", 36'd1, 36'd0);
    else check("result", 36'(o_result), 36'(exp_q.pop_front()));
    held = o_result;
    if (bp) begin
      for (int i = 0; i < 20; i++) begin
        check("bp_valid", 36'(o_valid), 36'd1);
        check("bp_result", 36'(o_result), 36'(held));
        check("bp_ce", 36'(o_rom_ce), 36'd0);
        check("bp_tri", 36'(o_rom_tri_output), 36'd1);
        c_start = (i == 5 || i == 12);
        @(posedge c_clk); #1;
      end
      c_start = 1'b0;
    end
    i_ready = 1'b1;
    c_start = bp;
    @(posedge c_clk); #1;
    i_ready = 1'b0; c_start = 1'b0;
    check("accept_valid", 36'(o_valid), 36'd0);
    check("accept_busy", 36'(o_busy), 36'd0);
    check("accept_hold", 36'(o_result), 36'(held));
    if (bp) begin
      @(posedge c_clk); #1;
      check("start_on_accept_ignored", 36'(o_busy), 36'd0);
    end
  endtask

  initial begin
    c_rst = 1'b1; c_start = 1'b0; i_ready = 1'b0;
    i_coef_wr = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    for (int k = 0; k < 8; k++) begin
      rom_mem[k] = 16'($urandom);
      coef_m[k]  = '0;
    end
    repeat (3) @(posedge c_clk);
    #1 c_rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_result", 36'(o_result), 36'd0);

    // single term, full-scale
    rom_mem[0] = 16'h7FFF;
    wr_coef(3'd0, 16'h7FFF);
    run(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("single_term", 36'(o_result), 36'h7FFE);

    // mixed sign, floored
    wr_coef(3'd0, 16'h0000);
    wr_coef(3'd1, 16'h4000);
    wr_coef(3'd2, 16'h4000);
    rom_mem[1] = 16'h2FFF; rom_mem[2] = 16'hA400;
    run(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("mixed_floor", 36'(o_result), 36'hE9FF);

    // saturation both ways, ready held high throughout
    for (int k = 0; k < 8; k++) begin
      wr_coef(3'(k), 16'h7FFF);
      rom_mem[k] = 16'h7FFF;
    end
    run(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    check("sat_pos", 36'(o_result), 36'h7FFF);
    for (int k = 0; k < 8; k++) rom_mem[k] = 16'h8000;
    run(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    check("sat_neg", 36'(o_result), 36'h8000);

    // backpressure with ignored starts
    for (int k = 0; k < 8; k++) begin
      wr_coef(3'(k), 16'h0000);
      rom_mem[k] = 16'(k * 16'h0931);
    end
    wr_coef(3'd1, 16'h4000);
    wr_coef(3'd2, 16'h4000);
    rom_mem[1] = 16'h2FFF; rom_mem[2] = 16'hA400;
    run(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("bp_mixed", 36'(o_result), 36'hE9FF);

    // reset at edge 4 of RUN
    c_start = 1'b1;
    @(posedge c_clk); #1;
    c_start = 1'b0;
    repeat (3) @(posedge c_clk);
    #1 c_rst = 1'b1;
    @(posedge c_clk); #1;
    c_rst = 1'b0;
    check_idle_outputs("midrun_rst");
    check("midrun_rst_result", 36'(o_result), 36'd0);
    for (int k = 0; k < 8; k++) coef_m[k] = '0;
    run(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("coefs_cleared", 36'(o_result), 36'd0);
    wr_coef(3'd1, 16'h4000);
    wr_coef(3'd2, 16'h4000);
    run(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("after_rst_rerun", 36'(o_result), 36'hE9FF);

    // coefficient write during RUN is dropped
    wr_coef(3'd3, 16'h0100);
    rom_mem[3] = 16'h7000;
    run(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

    // write on the accepted start edge takes effect
    rom_mem[0] = 16'h4000;
    run(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h2000);

    check("sb_drained", 36'(exp_q.size()), 36'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
